// File: rtl/sevenseg_mux.sv
// rtl/sevenseg_mux.sv - time-multiplexed seven-segment display driver
//
// Purpose:
//   Scans NUM_DIGITS seven-segment digits one slot at a time. Every slot
//   begins with GAP_CYCLES blank cycles (anti-ghosting), then the digit is
//   lit whenever the free-running PWM counter is <= in_bright. New values
//   are captured into pending registers and only copied to the displayed
//   (shadow) registers at a frame boundary, so a frame never mixes old and
//   new digits.
//
// Optional feature:
//   SEVENSEG_MUX_BLANK_ZEROS_EN - leading-zero blanking (digit 0 never blanked).
//
// Ports:
//   in_clk         system clock
//   in_rst         synchronous reset, active-high
//   in_update      strobe: capture in_value / in_dp into pending regs
//   in_value       packed hex digits, [3:0] = digit 0 (rightmost)
//   in_dp          decimal point per digit
//   in_bright      brightness, 0 = dimmest, all-ones = full on
//   out_leds       segment pattern of the active digit
//   out_dp         decimal point of the active digit
//   out_digit_sel  one-hot digit select, or all inactive
//   out_frame      one-cycle pulse aligned with the first outputs of digit 0

module sevenseg_mux #(
  parameter int NUM_DIGITS        = 4,
  parameter int MAIN_CLK          = 50000000,
  parameter int SCAN_CLK          = 1000,
  parameter int GAP_CYCLES        = 16,
  parameter int BRIGHT_BITS       = 3,
  parameter bit ZERO_IS_ON        = 1'b0,
  parameter bit SEL_ZERO_IS_ON    = 1'b0,
  parameter bit INVERSE_NUMBERING = 1'b0
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_update,
  input  logic [4*NUM_DIGITS-1:0]   in_value,
  input  logic [NUM_DIGITS-1:0]     in_dp,
  input  logic [BRIGHT_BITS-1:0]    in_bright,
  output logic [6:0]                out_leds,
  output logic                      out_dp,
  output logic [NUM_DIGITS-1:0]     out_digit_sel,
  output logic                      out_frame
);

  localparam int SLOT_LEN = MAIN_CLK / SCAN_CLK;
  localparam int SLOT_W   = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]      SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0]      GAP_END   = SLOT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Inactive levels of every pin, used both in reset and while a digit is off.
  localparam logic [6:0]             SEG_OFF   = {7{ZERO_IS_ON}};
  localparam logic                   DP_OFF    = ZERO_IS_ON;
  localparam logic [NUM_DIGITS-1:0]  SEL_OFF   = {NUM_DIGITS{SEL_ZERO_IS_ON}};

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [SLOT_W-1:0]        slot_ctr;
  logic [IDX_W-1:0]         idx;
  logic [BRIGHT_BITS-1:0]   pwm_ctr;

  logic [4*NUM_DIGITS-1:0]  shadow_value;
  logic [NUM_DIGITS-1:0]    shadow_dp;
  logic [4*NUM_DIGITS-1:0]  pend_value;
  logic [NUM_DIGITS-1:0]    pend_dp;
  logic                     pend_flag;

  // ------------------------------------------------------------------
  // Combinational next-output signals
  // ------------------------------------------------------------------
  logic                     slot_wrap;
  logic                     frame_wrap;
  logic [3:0]               cur_digit;
  logic                     cur_dp;
  logic [6:0]               seg_pattern;
  logic                     blanked;
  logic                     digit_on;
  logic [NUM_DIGITS-1:0]    sel_onehot;
  logic [6:0]               leds_next;
  logic                     dp_next;
  logic [NUM_DIGITS-1:0]    sel_next;
  logic                     frame_next;

  // Standard hex table, segment a on bit 6 down to g on bit 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h7e;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6d;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5b;
      4'h6:    seg = 7'h5f;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7f;
      4'h9:    seg = 7'h7b;
      4'ha:    seg = 7'h77;
      4'hb:    seg = 7'h1f;
      4'hc:    seg = 7'h4e;
      4'hd:    seg = 7'h3d;
      4'he:    seg = 7'h4f;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] reverse7(input logic [6:0] v);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) begin
      r[b] = v[6-b];
    end
    return r;
  endfunction

  assign slot_wrap  = (slot_ctr == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);

  // Select the shadow digit under scan. idx never exceeds NUM_DIGITS-1
  // because it wraps explicitly, so the part-select stays in range.
  always_comb begin
    cur_digit  = 4'h0;
    cur_dp     = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit     = shadow_value[4*i +: 4];
        cur_dp        = shadow_dp[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEVENSEG_MUX_BLANK_ZEROS_EN
  // zero_from[i]: digits i..NUM_DIGITS-1 are all 0 with no decimal point.
  logic [NUM_DIGITS-1:0] zero_from;

  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (shadow_value[4*(NUM_DIGITS-1) +: 4] == 4'h0) &&
                              !shadow_dp[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (shadow_value[4*i +: 4] == 4'h0) &&
                     !shadow_dp[i];
    end
  end

  always_comb begin
    blanked = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        blanked = zero_from[i];
      end
    end
  end
`else
  assign blanked = 1'b0;
`endif

  // in_bright is compared live so a brightness change acts on the next
  // PWM comparison without waiting for a frame boundary.
  assign digit_on = (slot_ctr >= GAP_END) && (pwm_ctr <= in_bright) && !blanked;

  always_comb begin
    seg_pattern = hex_to_seg(cur_digit);
    if (INVERSE_NUMBERING) begin
      seg_pattern = reverse7(seg_pattern);
    end
  end

  always_comb begin
    leds_next  = SEG_OFF;
    dp_next    = DP_OFF;
    sel_next   = SEL_OFF;
    // Registered alongside the digit-0 outputs so the pulse lines up with
    // the first pin values of the new frame.
    frame_next = (slot_ctr == '0) && (idx == '0);
    if (digit_on) begin
      leds_next = seg_pattern ^ SEG_OFF;
      dp_next   = cur_dp ^ DP_OFF;
      sel_next  = sel_onehot ^ SEL_OFF;
    end
  end

  // ------------------------------------------------------------------
  // Counters, tear-free value capture and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      slot_ctr      <= '0;
      idx           <= '0;
      pwm_ctr       <= '0;
      shadow_value  <= '0;
      shadow_dp     <= '0;
      pend_value    <= '0;
      pend_dp       <= '0;
      pend_flag     <= 1'b0;
      out_leds      <= SEG_OFF;
      out_dp        <= DP_OFF;
      out_digit_sel <= SEL_OFF;
      out_frame     <= 1'b0;
    end else begin
      pwm_ctr <= pwm_ctr + BRIGHT_BITS'(1);

      if (slot_wrap) begin
        slot_ctr <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_ctr <= slot_ctr + SLOT_W'(1);
      end

      if (frame_wrap && pend_flag) begin
        shadow_value <= pend_value;
        shadow_dp    <= pend_dp;
        pend_flag    <= 1'b0;
      end

      // Placed after the boundary copy so a strobe in the boundary cycle
      // keeps the flag set and lands in the following frame.
      if (in_update) begin
        pend_value <= in_value;
        pend_dp    <= in_dp;
        pend_flag  <= 1'b1;
      end

      out_leds      <= leds_next;
      out_dp        <= dp_next;
      out_digit_sel <= sel_next;
      out_frame     <= frame_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux.sv
// tb/tb_sevenseg_mux.sv - self-checking bench for sevenseg_mux

module tb_sevenseg_mux;

  localparam int ND = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            upd;
  logic [15:0]     val;
  logic [3:0]      dpi;
  logic [2:0]      bright;

  logic [6:0]      leds;
  logic            dp;
  logic [3:0]      sel;
  logic            frame;

  logic [6:0]      n_leds;
  logic            n_dp;
  logic [3:0]      n_sel;
  logic            n_frame;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] leds;
    logic       dp;
    int         on;
    bit         bad;
  } slot_t;

  slot_t exp_q[$];
  slot_t obs_q[$];

  logic [6:0] seg_tab [16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                               7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};

  always #5 clk = ~clk;

  sevenseg_mux #(
    .NUM_DIGITS(ND), .MAIN_CLK(1000), .SCAN_CLK(100), .GAP_CYCLES(2), .BRIGHT_BITS(3)
  ) dut (
    .in_clk(clk), .in_rst(rst), .in_update(upd), .in_value(val), .in_dp(dpi),
    .in_bright(bright), .out_leds(leds), .out_dp(dp), .out_digit_sel(sel),
    .out_frame(frame)
  );

  sevenseg_mux #(
    .NUM_DIGITS(ND), .MAIN_CLK(1000), .SCAN_CLK(100), .GAP_CYCLES(2), .BRIGHT_BITS(3),
    .ZERO_IS_ON(1'b1), .SEL_ZERO_IS_ON(1'b1)
  ) dut_n (
    .in_clk(clk), .in_rst(rst), .in_update(upd), .in_value(val), .in_dp(dpi),
    .in_bright(bright), .out_leds(n_leds), .out_dp(n_dp), .out_digit_sel(n_sel),
    .out_frame(n_frame)
  );

  function automatic bit is_blank(input logic [15:0] v, input logic [3:0] d, input int k);
    bit b = 1'b0;
`ifdef SEVENSEG_MUX_BLANK_ZEROS_EN
    if (k > 0) begin
      b = 1'b1;
      for (int i = k; i < ND; i++) begin
        if (v[4*i +: 4] != 4'h0 || d[i]) b = 1'b0;
      end
    end
`endif
    return b;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int on);
    for (int k = 0; k < ND; k++) begin
      slot_t e;
      if (is_blank(v, d, k)) begin
        e = '{sel: 4'b0, leds: 7'h0, dp: 1'b0, on: 0, bad: 1'b0};
      end else begin
        e = '{sel: 4'b1 << k, leds: seg_tab[v[4*k +: 4]], dp: d[k], on: on, bad: 1'b0};
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic sync_frame(output bit got);
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (frame === 1'b1) got = 1'b1;
    end
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] d);
    val = v;
    dpi = d;
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  // Records one full frame of the default instance into obs_q.
  task automatic capture_frame(output bit got);
    obs_q.delete();
    sync_frame(got);
    if (got) begin
      for (int k = 0; k < ND; k++) begin
        slot_t o = '{sel: 4'b0, leds: 7'h0, dp: 1'b0, on: 0, bad: 1'b0};
        for (int j = 0; j < 10; j++) begin
          if (k != 0 || j != 0) @(negedge clk);
          if (frame === 1'b1 && (k != 0 || j != 0)) o.bad = 1'b1;
          if (sel !== 4'b0) begin
            if (j < 2) o.bad = 1'b1;
            if (o.on == 0) begin
              o.sel = sel; o.leds = leds; o.dp = dp;
            end else if (sel !== o.sel || leds !== o.leds || dp !== o.dp) begin
              o.bad = 1'b1;
            end
            o.on++;
          end else if (leds !== 7'h0 || dp !== 1'b0) begin
            o.bad = 1'b1;
          end
        end
        obs_q.push_back(o);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; upd = 1'b0; val = '0; dpi = '0; bright = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({sel, leds, dp, frame} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_default: got sel=%b leds=%h dp=%b frame=%b, want all 0", sel, leds, dp, frame);
    end
    n_cmp++;
    if ({n_sel, n_leds, n_dp, n_frame} !== {4'hf, 7'h7f, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_inverted: got sel=%b leds=%h dp=%b frame=%b, want sel=1111 leds=7f dp=1 frame=0",
               n_sel, n_leds, n_dp, n_frame);
    end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      logic [3:0] want;
      @(negedge clk);
      want = (e == 3) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (sel !== want) begin
        n_bad++;
        $display("FAIL first_select cycle %0d: got sel=%b, want %b", e, sel, want);
      end
    end
  endtask

  task automatic test_display;
    bit got;
    slot_t e, o;
    sync_frame(got);
    strobe(16'h12ab, 4'b0100);
    push_frame(16'h12ab, 4'b0100, 8);
    capture_frame(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL display_timeout: got no frame, want frame pulse");
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '{sel: 4'hx, leds: 7'hx, dp: 1'bx, on: -1, bad: 1'b1};
      n_cmp++;
      if (o.sel !== e.sel || o.leds !== e.leds || o.dp !== e.dp || o.on != e.on || o.bad) begin
        n_bad++;
        $display("FAIL display slot %0d: got sel=%b leds=%h dp=%b on=%0d bad=%b, want sel=%b leds=%h dp=%b on=%0d",
                 k, o.sel, o.leds, o.dp, o.on, o.bad, e.sel, e.leds, e.dp, e.on);
      end
    end
  endtask

  task automatic test_last_write_wins;
    bit got;
    slot_t e, o;
    logic [11:0] want;
    sync_frame(got);
    // r counts cycles from the frame pulse of the frame currently showing 12ab
    strobe(16'h1111, 4'b0000);
    @(negedge clk);
    strobe(16'h2222, 4'b0000);
    for (int r = 4; r <= 35; r++) begin
      @(negedge clk);
      if (r == 15 || r == 25 || r == 35) begin
        case (r)
          15:      want = {4'b0010, 7'h77, 1'b0};
          25:      want = {4'b0100, 7'h6d, 1'b1};
          default: want = {4'b1000, 7'h30, 1'b0};
        endcase
        n_cmp++;
        if ({sel, leds, dp} !== want) begin
          n_bad++;
          $display("FAIL no_tear r=%0d: got sel/leds/dp=%h, want %h", r, {sel, leds, dp}, want);
        end
      end
    end
    push_frame(16'h2222, 4'b0000, 8);
    capture_frame(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL last_write_timeout: got no frame, want frame pulse");
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '{sel: 4'hx, leds: 7'hx, dp: 1'bx, on: -1, bad: 1'b1};
      n_cmp++;
      if (o.sel !== e.sel || o.leds !== e.leds || o.dp !== e.dp || o.on != e.on || o.bad) begin
        n_bad++;
        $display("FAIL last_write slot %0d: got sel=%b leds=%h dp=%b on=%0d bad=%b, want sel=%b leds=%h dp=%b on=%0d",
                 k, o.sel, o.leds, o.dp, o.on, o.bad, e.sel, e.leds, e.dp, e.on);
      end
    end
  endtask

  task automatic test_brightness;
    bit got;
    slot_t e, o;
    int levels [2] = '{0, 3};
    for (int l = 0; l < 2; l++) begin
      bright = 3'(levels[l]);
      // Eight on-slot cycles cover every pwm value once, so on = bright+1.
      push_frame(16'h2222, 4'b0000, levels[l] + 1);
      capture_frame(got);
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("FAIL bright_timeout: got no frame, want frame pulse");
      end
      for (int k = 0; exp_q.size() > 0; k++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '{sel: 4'hx, leds: 7'hx, dp: 1'bx, on: -1, bad: 1'b1};
        n_cmp++;
        if (o.sel !== e.sel || o.leds !== e.leds || o.dp !== e.dp || o.on != e.on || o.bad) begin
          n_bad++;
          $display("FAIL bright%0d slot %0d: got sel=%b leds=%h on=%0d bad=%b, want sel=%b leds=%h on=%0d",
                   levels[l], k, o.sel, o.leds, o.on, o.bad, e.sel, e.leds, e.on);
        end
      end
    end
    bright = 3'd7;
  endtask

  task automatic test_zeros;
    bit got;
    slot_t e, o;
    sync_frame(got);
    strobe(16'h0040, 4'b0000);
    push_frame(16'h0040, 4'b0000, 8);
    capture_frame(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL zeros_timeout: got no frame, want frame pulse");
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '{sel: 4'hx, leds: 7'hx, dp: 1'bx, on: -1, bad: 1'b1};
      n_cmp++;
      if (o.sel !== e.sel || o.leds !== e.leds || o.dp !== e.dp || o.on != e.on || o.bad) begin
        n_bad++;
        $display("FAIL zeros slot %0d: got sel=%b leds=%h dp=%b on=%0d bad=%b, want sel=%b leds=%h dp=%b on=%0d",
                 k, o.sel, o.leds, o.dp, o.on, o.bad, e.sel, e.leds, e.dp, e.on);
      end
    end
  endtask

  task automatic test_polarity;
    bit got;
    bit on;
    logic [11:0] want_n, want_p;
    sync_frame(got);
    strobe(16'h0000, 4'b0000);
    sync_frame(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL polarity_timeout: got no frame, want frame pulse");
    end
    for (int r = 0; r < 40; r++) begin
      if (r != 0) @(negedge clk);
      on = (r % 10 >= 2) && !is_blank(16'h0, 4'h0, r / 10);
      want_p = on ? {4'b1 << (r / 10), 7'h7e, 1'b0} : 12'h0;
      want_n = on ? {~(4'b1 << (r / 10)), ~7'h7e, 1'b1} : {4'hf, 7'h7f, 1'b1};
      n_cmp++;
      if ({n_sel, n_leds, n_dp} !== want_n || {sel, leds, dp} !== want_p) begin
        n_bad++;
        $display("FAIL polarity r=%0d: got inv=%h norm=%h, want inv=%h norm=%h",
                 r, {n_sel, n_leds, n_dp}, {sel, leds, dp}, want_n, want_p);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    bit got;
    slot_t e, o;
    sync_frame(got);
    strobe(16'h5678, 4'b1111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sel, leds, dp, frame} !== 12'h0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got sel=%b leds=%h dp=%b frame=%b, want all 0", sel, leds, dp, frame);
    end
    rst = 1'b0;
    // Two frames: the pending 5678 must be gone, never reaching shadow.
    for (int f = 0; f < 2; f++) begin
      push_frame(16'h0000, 4'b0000, 8);
      capture_frame(got);
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("FAIL mid_reset_timeout: got no frame, want frame pulse");
      end
      for (int k = 0; exp_q.size() > 0; k++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '{sel: 4'hx, leds: 7'hx, dp: 1'bx, on: -1, bad: 1'b1};
        n_cmp++;
        if (o.sel !== e.sel || o.leds !== e.leds || o.dp !== e.dp || o.on != e.on || o.bad) begin
          n_bad++;
          $display("FAIL mid_reset f%0d slot %0d: got sel=%b leds=%h dp=%b on=%0d bad=%b, want sel=%b leds=%h dp=%b on=%0d",
                   f, k, o.sel, o.leds, o.dp, o.on, o.bad, e.sel, e.leds, e.dp, e.on);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_last_write_wins();
    test_brightness();
    test_zeros();
    test_polarity();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
